// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states and port selects.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one slow line memory between the I-cache and D-cache.
// One transaction in flight; every output comes straight from a register.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LINE_W = 128,
  parameter int ADDR_W = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [LINE_W-1:0] i_mem_wdata,
  output logic [LINE_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  state_e              state_q, state_d;
  port_e               last_grant_q, last_grant_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                i_ready_q, i_ready_d;
  logic                d_ready_q, d_ready_d;
  logic [LINE_W-1:0]   i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0]   d_rdata_q, d_rdata_d;

  logic                i_req, d_req, win_write;
  port_e               win;

  assign i_req = i_mem_read | i_mem_write;
  assign d_req = d_mem_read | d_mem_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= PORT_D;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_ready_q    <= i_ready_d;
      d_ready_q    <= d_ready_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_ready_d    = i_ready_q;
    d_ready_d    = d_ready_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    win          = PORT_I;
    win_write    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          // Contention goes to whichever port did not win last time.
          if (i_req && d_req) begin
            win = (last_grant_q == PORT_I) ? PORT_D : PORT_I;
          end else begin
            win = d_req ? PORT_D : PORT_I;
          end
          win_write    = (win == PORT_D) ? d_mem_write : i_mem_write;
          last_grant_d = win;
          mem_write_d  = win_write;
          mem_read_d   = !win_write;
          mem_addr_d   = (win == PORT_D) ? d_mem_addr : i_mem_addr;
          mem_wdata_d  = (win == PORT_D) ? d_mem_wdata : i_mem_wdata;
          state_d      = ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (mem_ready) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          // mem_read_q still carries the op of the transaction completing here.
          if (last_grant_q == PORT_D) begin
            d_ready_d = 1'b1;
            if (mem_read_q) d_rdata_d = mem_rdata;
          end else begin
            i_ready_d = 1'b1;
            if (mem_read_q) i_rdata_d = mem_rdata;
          end
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        i_ready_d = 1'b0;
        d_ready_d = 1'b0;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign i_mem_ready = i_ready_q;
  assign d_mem_ready = d_ready_q;
  assign i_mem_rdata = i_rdata_q;
  assign d_mem_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences,
// and a randomized two-port run against a transaction-level round-robin model.
module tb_mem_arbiter;

  localparam int LW = 128;
  localparam int AW = 28;

  logic          clk;
  logic          rst_n;
  logic          i_mem_read, i_mem_write, d_mem_read, d_mem_write;
  logic [AW-1:0] i_mem_addr, d_mem_addr, mem_addr;
  logic [LW-1:0] i_mem_wdata, d_mem_wdata, mem_wdata;
  logic [LW-1:0] i_mem_rdata, d_mem_rdata, mem_rdata;
  logic          i_mem_ready, d_mem_ready, mem_read, mem_write, mem_ready;

  mem_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata),
    .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata),
    .d_mem_rdata(d_mem_rdata), .d_mem_ready(d_mem_ready),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Slow-memory model state
  int            mem_cnt = 0;
  int            mem_lat = 1;
  logic [LW-1:0] mem_data_v = '0;
  logic [LW-1:0] resp_data = '0;
  bit            rand_mode = 0;
  bit            stray_req = 0;

  typedef struct {
    bit            port;
    bit            rd;
    bit            wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    int            lat;
    logic [LW-1:0] rdata;
    bit            exp_w;
    bit            exp_r;
    int            exp_hi;
    logic [LW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive_i(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] wd);
    i_mem_read = rd; i_mem_write = wr; i_mem_addr = a; i_mem_wdata = wd;
  endtask

  task automatic drive_d(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] wd);
    d_mem_read = rd; d_mem_write = wr; d_mem_addr = a; d_mem_wdata = wd;
  endtask

  // One cycle: wait for the falling edge, run the memory model, check invariants.
  task automatic tick();
    @(negedge clk);
    mem_ready = 1'b0;
    if (!rst_n) begin
      mem_cnt = 0;
    end else if (stray_req) begin
      mem_ready = 1'b1;
      stray_req = 0;
    end else if (mem_read || mem_write) begin
      mem_cnt++;
      if (mem_cnt >= mem_lat) begin
        mem_ready = 1'b1;
        mem_cnt   = 0;
        mem_rdata = rand_mode ? {$urandom, $urandom, $urandom, $urandom} : mem_data_v;
        resp_data = mem_rdata;
        if (rand_mode) mem_lat = $urandom_range(1, 6);
      end
    end else begin
      mem_cnt = 0;
    end
    chk("ready_exclusive", LW'(i_mem_ready && d_mem_ready), '0);
    chk("strobe_exclusive", LW'(mem_read && mem_write), '0);
  endtask

  // Runs until a port ready appears; reports the first strobe cycle seen.
  task automatic wait_txn(output bit ok, output bit port, output bit w, output bit r,
                          output logic [AW-1:0] a, output logic [LW-1:0] wd,
                          output int hi, output int first, output bit gap_ok);
    bit seen = 0;
    bit prev = 0;
    ok = 0; port = 0; w = 0; r = 0; a = '0; wd = '0; hi = 0; first = -1; gap_ok = 0;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (i_mem_ready || d_mem_ready) begin
        port   = d_mem_ready;
        ok     = 1;
        gap_ok = prev && !(mem_read || mem_write);
        break;
      end
      if (mem_read || mem_write) begin
        if (!seen) begin
          seen = 1; w = mem_write; r = mem_read; a = mem_addr; wd = mem_wdata; first = n;
        end
        hi++;
        prev = 1;
      end else begin
        prev = 0;
      end
    end
    chk("txn_completes", LW'(ok), LW'(1));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_read"}, LW'(mem_read), '0);
    chk({tag, "_mem_write"}, LW'(mem_write), '0);
    chk({tag, "_mem_addr"}, LW'(mem_addr), '0);
    chk({tag, "_mem_wdata"}, mem_wdata, '0);
    chk({tag, "_i_ready"}, LW'(i_mem_ready), '0);
    chk({tag, "_d_ready"}, LW'(d_mem_ready), '0);
    chk({tag, "_i_rdata"}, i_mem_rdata, '0);
    chk({tag, "_d_rdata"}, d_mem_rdata, '0);
  endtask

  initial begin
    bit            ok, port, w, r, gap_ok;
    logic [AW-1:0] a;
    logic [LW-1:0] wd;
    int            hi, first;
    bit            exp_ports[4];
    logic [AW-1:0] s_addr, s_prev_addr;
    logic [LW-1:0] s_wdata, s_irdata, s_drdata;

    rst_n = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = '0;
    drive_i(0, 0, '0, '0);
    drive_d(0, 0, '0, '0);
    #2 rst_n = 1'b0;
    #2 check_all_zero("reset");
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // ---- directed vector table (single requester each) ----
    vecs[0] = '{0, 1, 0, 28'h0000010, '0, 5, {16{8'hA5}}, 0, 1, 5, {16{8'hA5}}};
    vecs[1] = '{1, 1, 1, 28'h0000300, 128'hDEAD, 2, {16{8'h77}}, 1, 0, 2, '0};
    vecs[2] = '{1, 1, 0, 28'h0000044, '0, 1, {16{8'h5A}}, 0, 1, 1, {16{8'h5A}}};
    vecs[3] = '{0, 0, 1, 28'hFFFFFFF, '1, 3, {16{8'h33}}, 1, 0, 3, {16{8'hA5}}};
    vecs[4] = '{1, 0, 1, 28'h0000200, 128'h1234, 4, {16{8'h11}}, 1, 0, 4, {16{8'h5A}}};

    for (int k = 0; k < 5; k++) begin
      mem_lat    = vecs[k].lat;
      mem_data_v = vecs[k].rdata;
      if (vecs[k].port) drive_d(vecs[k].rd, vecs[k].wr, vecs[k].addr, vecs[k].wdata);
      else              drive_i(vecs[k].rd, vecs[k].wr, vecs[k].addr, vecs[k].wdata);
      wait_txn(ok, port, w, r, a, wd, hi, first, gap_ok);
      drive_i(0, 0, '0, '0);
      drive_d(0, 0, '0, '0);
      chk($sformatf("vec%0d_port", k), LW'(port), LW'(vecs[k].port));
      chk($sformatf("vec%0d_mem_write", k), LW'(w), LW'(vecs[k].exp_w));
      chk($sformatf("vec%0d_mem_read", k), LW'(r), LW'(vecs[k].exp_r));
      chk($sformatf("vec%0d_addr", k), LW'(a), LW'(vecs[k].addr));
      chk($sformatf("vec%0d_wdata", k), wd, vecs[k].wdata);
      chk($sformatf("vec%0d_strobe_cycles", k), LW'(hi), LW'(vecs[k].exp_hi));
      chk($sformatf("vec%0d_strobe_latency", k), LW'(first), '0);
      chk($sformatf("vec%0d_ready_after_mem", k), LW'(gap_ok), LW'(1));
      chk($sformatf("vec%0d_rdata", k), vecs[k].port ? d_mem_rdata : i_mem_rdata, vecs[k].exp_rdata);
      tick();
      chk($sformatf("vec%0d_ready_one_cycle", k), LW'(i_mem_ready || d_mem_ready), '0);
      $display("vec%0d port=%0d w=%0d addr=%h strobe_cycles=%0d", k, port, w, a, hi);
    end

    // ---- spurious mem_ready while idle ----
    tick();
    s_addr = mem_addr; s_wdata = mem_wdata; s_irdata = i_mem_rdata; s_drdata = d_mem_rdata;
    mem_data_v = {16{8'hEE}};
    mem_rdata  = mem_data_v;
    stray_req  = 1;
    tick(); tick();
    chk("idle_stray_strobe", LW'(mem_read || mem_write), '0);
    chk("idle_stray_ready", LW'(i_mem_ready || d_mem_ready), '0);
    chk("idle_stray_addr", LW'(mem_addr), LW'(s_addr));
    chk("idle_stray_wdata", mem_wdata, s_wdata);
    chk("idle_stray_i_rdata", i_mem_rdata, s_irdata);
    chk("idle_stray_d_rdata", d_mem_rdata, s_drdata);
    $display("idle stray mem_ready: no change expected");

    // ---- simultaneous I read / D write right after reset ----
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    mem_lat = 2;
    mem_data_v = {16{8'hC3}};
    drive_i(1, 0, 28'h0000020, '0);
    drive_d(0, 1, 28'h0000200, 128'h1234);
    wait_txn(ok, port, w, r, a, wd, hi, first, gap_ok);
    drive_i(0, 0, '0, '0);
    chk("sim_first_port", LW'(port), LW'(0));
    chk("sim_first_read", LW'(r), LW'(1));
    chk("sim_first_rdata", i_mem_rdata, {16{8'hC3}});
    wait_txn(ok, port, w, r, a, wd, hi, first, gap_ok);
    drive_d(0, 0, '0, '0);
    chk("sim_second_port", LW'(port), LW'(1));
    chk("sim_second_write", LW'(w), LW'(1));
    chk("sim_second_addr", LW'(a), LW'(28'h0000200));
    chk("sim_second_wdata", wd, 128'h1234);
    chk("sim_second_after_resp", LW'(first), LW'(1));
    chk("sim_d_rdata_kept", d_mem_rdata, '0);
    $display("simultaneous: I then D write addr=%h", a);

    // ---- both held continuously: grants alternate starting with I ----
    exp_ports = '{0, 1, 0, 1};
    drive_i(1, 0, 28'h0000111, '0);
    drive_d(1, 0, 28'h0000222, '0);
    s_prev_addr = '0;
    for (int k = 0; k < 4; k++) begin
      wait_txn(ok, port, w, r, a, wd, hi, first, gap_ok);
      chk($sformatf("rr%0d_port", k), LW'(port), LW'(exp_ports[k]));
      chk($sformatf("rr%0d_addr", k), LW'(a), exp_ports[k] ? LW'(28'h0000222) : LW'(28'h0000111));
      $display("round-robin txn %0d granted port=%0d addr=%h", k, port, a);
    end
    drive_i(0, 0, '0, '0);
    drive_d(0, 0, '0, '0);
    tick(); tick();

    // ---- reset mid-BUSY, then stray mem_ready ----
    mem_lat = 10;
    drive_i(1, 0, 28'h0000400, '0);
    tick(); tick();
    chk("midbusy_strobe_up", LW'(mem_read), LW'(1));
    rst_n = 1'b0;
    drive_i(0, 0, '0, '0);
    #1 check_all_zero("async_reset");
    tick();
    rst_n = 1'b1;
    stray_req = 1;
    tick(); tick(); tick();
    check_all_zero("post_reset_stray");
    $display("reset mid-BUSY then stray mem_ready: outputs idle");

    // ---- randomized two-port run against a transaction-level model ----
    begin
      bit            pend[2], pwr[2], prd[2], snap[2];
      logic [AW-1:0] paddr[2];
      logic [LW-1:0] pwdata[2], mdl_rdata[2];
      bit            mdl_last, inflight, prev_strobe, strobe, win, p;
      int            done, guard;
      mdl_last = 1; inflight = 0; prev_strobe = 0;
      mdl_rdata[0] = '0; mdl_rdata[1] = '0;
      for (int q = 0; q < 2; q++) begin
        pend[q] = 0; pwr[q] = 0; prd[q] = 0; snap[q] = 0; paddr[q] = '0; pwdata[q] = '0;
      end
      rand_mode = 1;
      mem_lat = $urandom_range(1, 6);
      done = 0;
      guard = 0;
      while (done < 60 && guard < 5000) begin
        guard++;
        tick();
        strobe = mem_read || mem_write;
        if (strobe && !prev_strobe) begin
          win = (snap[0] && snap[1]) ? !mdl_last : snap[1];
          mdl_last = win;
          inflight = win;
          chk("rnd_grant_addr", LW'(mem_addr), LW'(paddr[win]));
          chk("rnd_grant_wdata", mem_wdata, pwdata[win]);
          chk("rnd_grant_write", LW'(mem_write), LW'(pwr[win]));
          chk("rnd_grant_read", LW'(mem_read), LW'(!pwr[win]));
        end
        if (i_mem_ready || d_mem_ready) begin
          p = d_mem_ready;
          chk("rnd_ready_port", LW'(p), LW'(inflight));
          if (!pwr[p]) mdl_rdata[p] = resp_data;
          chk("rnd_i_rdata", i_mem_rdata, mdl_rdata[0]);
          chk("rnd_d_rdata", d_mem_rdata, mdl_rdata[1]);
          $display("rnd txn %0d port=%0d write=%0d addr=%h", done, p, pwr[p], paddr[p]);
          pend[p] = 0;
          done++;
        end
        for (int q = 0; q < 2; q++) begin
          if (!pend[q] && $urandom_range(0, 2) != 0) begin
            int op = $urandom_range(1, 3);
            pend[q]   = 1;
            prd[q]    = (op != 2);
            pwr[q]    = (op != 1);
            paddr[q]  = AW'($urandom);
            pwdata[q] = {$urandom, $urandom, $urandom, $urandom};
          end
        end
        drive_i(pend[0] && prd[0], pend[0] && pwr[0], pend[0] ? paddr[0] : '0, pend[0] ? pwdata[0] : '0);
        drive_d(pend[1] && prd[1], pend[1] && pwr[1], pend[1] ? paddr[1] : '0, pend[1] ? pwdata[1] : '0);
        snap[0] = pend[0];
        snap[1] = pend[1];
        prev_strobe = strobe;
      end
      chk("rnd_all_done", LW'(done), LW'(60));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LINE_W, default 128, cache-line/data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 28, line-address width (byte address bits 31:4).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports i_mem_read, i_mem_write  input  1 each  I-cache request strobes, held until i_mem_ready.
REQ-006 SHALL have ports i_mem_addr  input  ADDR_W, and i_mem_wdata  input  LINE_W  I-cache request address/data.
REQ-007 SHALL have ports i_mem_rdata  output  LINE_W, and i_mem_ready  output  1  I-cache response.
REQ-008 SHALL have ports d_mem_read, d_mem_write  input  1 each; d_mem_addr  input  ADDR_W; d_mem_wdata  input  LINE_W  D-cache request.
REQ-009 SHALL have ports d_mem_rdata  output  LINE_W, and d_mem_ready  output  1  D-cache response.
REQ-010 SHALL have ports mem_read, mem_write  output  1 each; mem_addr  output  ADDR_W; mem_wdata  output  LINE_W  shared slow-memory request.
REQ-011 SHALL have ports mem_rdata  input  LINE_W, and mem_ready  input  1  slow-memory response, ready is a 1-cycle pulse.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-013 IDLE: a port is requesting when its read or write strobe is 1; with no requester, stay IDLE.
REQ-014 IDLE, one requester: at the clock edge, grant it, latch its addr, wdata and op into registers, and go to BUSY.
REQ-015 IDLE, both requesting: grant the port not in last_grant (round-robin); update last_grant to the winner.
REQ-016 Op decode: write strobe set -> write op (mem_write=1, mem_read=0), even if read is also set; otherwise read op.
REQ-017 BUSY: drive mem_read/mem_write/mem_addr/mem_wdata only from the latched registers; hold them stable until mem_ready.
REQ-018 BUSY with mem_ready=1: at that edge, deassert mem_read/mem_write, set the granted port's ready register to 1, and go to RESP.
REQ-019 Read op completion: load mem_rdata into the granted port's rdata register at the same edge.
REQ-020 Write op completion: leave that port's rdata register unchanged.
REQ-021 RESP: granted ready is high for exactly one cycle; clear it at the next edge and return to IDLE.
REQ-022 Request strobes are not sampled for arbitration in BUSY or RESP.
REQ-023 Latency: request seen in IDLE at edge t -> mem strobe high in cycle t+1; mem_ready in cycle c -> port ready high in cycle c+1.
REQ-024 mem_ready in IDLE or RESP is ignored, with no state or output change.
REQ-025 Request-strobe changes during BUSY do not alter the in-flight transaction.
REQ-026 i_mem_ready and d_mem_ready are never high in the same cycle.
REQ-027 mem_read and mem_write are never high together.

Reset
REQ-028 While rst_n=0, asynchronously: state=IDLE, last_grant=D, all ready/mem strobes 0, mem_addr 0, mem_wdata 0, rdata registers 0.
REQ-029 Reset during BUSY abandons the transaction; a later mem_ready pulse is ignored per REQ-024.

Structure
REQ-030 FSM state encoding and port-select encoding (I=0, D=1) SHALL live in a shared package mem_arb_pkg.
REQ-031 The block SHALL be one module with no sub-module; all outputs SHALL be registered.

Verification
REQ-032 I read only, addr 0x0000010, memory ready after 5 cycles with rdata 0xA5..A5 -> mem_read high 5 cycles, i_mem_ready 1 cycle after mem_ready, i_mem_rdata=0xA5..A5.
REQ-033 I read and D write simultaneous after reset -> I served first; D write (addr 0x0000200, wdata 0x1234) issued after I's RESP; d_mem_rdata unchanged.
REQ-034 I and D both held continuously for 4 transactions -> grants alternate I, D, I, D.
REQ-035 D asserts read and write together, addr 0x0000300 -> mem_write=1, mem_read=0.
REQ-036 rst_n pulsed low mid-BUSY, then stray mem_ready -> all outputs 0, FSM IDLE, no port ready.
REQ-037 Spurious mem_ready in IDLE -> no output change.
